m1crypto_core: RTL and testbench

- Bit-serial MIFARE Classic Crypto1 stream-cipher core: 48-bit LFSR plus the standard two-layer nonlinear filter.
- Holds the sector key state and advances one bit per `start` strobe.
- Each step emits one keystream bit and absorbs one serial input bit (UID/nonce bit, optionally with encrypted-feedback).
- Sits between the 14443-A bit framer and the authentication/encryption controller.

---
 rtl/m1crypto_core.sv | 67 ++++++
 tb/tb_m1crypto_core.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/m1crypto_core.sv
// Crypto1 stream-cipher core: 48-bit LFSR with two-layer nonlinear filter,
// stepped one bit per start strobe, absorbing one serial bit per step.
module m1crypto_core (
  input  logic        sysclk,
  input  logic        resetn,
  input  logic [47:0] key,
  input  logic        load_key,
  input  logic        ser_in,
  input  logic        start,
  input  logic        fb,
  output logic        trx_ks,
  output logic        trx_fout
);

  localparam int unsigned StateW = 48;

  logic [StateW-1:0] x;
  logic [StateW-1:0] key_perm;
  logic              lin;
  logic              feed;

  function automatic logic filt_a(input logic a, input logic b, input logic c, input logic d);
    return ((a | b) ^ (a & d)) ^ (c & ((a ^ b) | d));
  endfunction

  function automatic logic filt_b(input logic a, input logic b, input logic c, input logic d);
    return ((a & b) | c) ^ ((a ^ b) & (c | d));
  endfunction

  function automatic logic filt_c(input logic a, input logic b, input logic c,
                                  input logic d, input logic e);
    return (a | ((b | e) & (d ^ e))) ^ ((a ^ (b & d)) & ((c ^ d) | (b & e)));
  endfunction

  // Key bytes enter MSB byte first, each byte LSB first.
  always_comb begin
    key_perm = '0;
    for (int p = 0; p < 48; p++) begin
      key_perm[p] = key[6'((47 - p) ^ 7)];
    end
  end

  always_comb begin
    trx_fout = filt_c(filt_a(x[9],  x[11], x[13], x[15]),
                      filt_b(x[17], x[19], x[21], x[23]),
                      filt_b(x[25], x[27], x[29], x[31]),
                      filt_a(x[33], x[35], x[37], x[39]),
                      filt_b(x[41], x[43], x[45], x[47]));
    lin  = x[0]  ^ x[5]  ^ x[9]  ^ x[10] ^ x[12] ^ x[14] ^ x[15] ^ x[17] ^ x[19] ^
           x[24] ^ x[25] ^ x[27] ^ x[29] ^ x[35] ^ x[39] ^ x[41] ^ x[42] ^ x[43];
    feed = lin ^ ser_in ^ (fb & trx_fout);
  end

  // Reset beats key load, key load beats step.
  always_ff @(posedge sysclk) begin
    if (resetn) begin
      x      <= '0;
      trx_ks <= 1'b0;
    end else if (load_key) begin
      x <= key_perm;
    end else if (start) begin
      x      <= {feed, x[StateW-1:1]};
      trx_ks <= trx_fout;
    end
  end

endmodule

// File: tb/tb_m1crypto_core.sv
// Directed scoreboard bench for m1crypto_core using known Crypto1 keystream words.
module tb_m1crypto_core;

  logic        sysclk = 1'b0;
  logic        resetn;
  logic [47:0] key;
  logic        load_key;
  logic        ser_in;
  logic        start;
  logic        fb;
  logic        trx_ks;
  logic        trx_fout;

  int checks = 0;
  int errors = 0;
  logic sb_q[$];

  m1crypto_core dut (
    .sysclk   (sysclk),
    .resetn   (resetn),
    .key      (key),
    .load_key (load_key),
    .ser_in   (ser_in),
    .start    (start),
    .fb       (fb),
    .trx_ks   (trx_ks),
    .trx_fout (trx_fout)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b1;
    tick();
    tick();
    resetn = 1'b0;
  endtask

  task automatic load(input logic [47:0] k);
    key      = k;
    load_key = 1'b1;
    tick();
    load_key = 1'b0;
  endtask

  // One step: fout ahead of the edge and ks after it must both match exp_bit.
  task automatic step_bit(input string tag, input logic din, input logic exp_bit,
                          output logic got);
    logic want;
    ser_in = din;
    start  = 1'b1;
    #1;
    check({tag, "_fout"}, 32'(trx_fout), 32'(exp_bit));
    sb_q.push_back(exp_bit);
    tick();
    start = 1'b0;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      want = 1'bx;
    end else begin
      want = sb_q.pop_front();
    end
    got = trx_ks;
    check({tag, "_ks"}, 32'(trx_ks), 32'(want));
  endtask

  task automatic run_word(input string tag, input logic [31:0] din,
                          input logic [31:0] exp, input int gap);
    logic [31:0] acc;
    logic        b;
    logic        held;
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      step_bit(tag, din[i], exp[i], b);
      acc[i] = b;
      if (gap > 0) begin
        held = trx_ks;
        for (int g = 0; g < gap; g++) tick();
        check({tag, "_hold"}, 32'(trx_ks), 32'(exp[i]));
        check({tag, "_hold_stable"}, 32'(trx_ks), 32'(held));
      end
    end
    check({tag, "_word"}, acc, exp);
  endtask

  initial begin
    logic [31:0] w0;
    logic        b;
    resetn   = 1'b1;
    key      = '0;
    load_key = 1'b0;
    ser_in   = 1'b0;
    start    = 1'b0;
    fb       = 1'b1;

    do_reset();
    check("reset_ks", 32'(trx_ks), 32'd0);
    check("reset_fout", 32'(trx_fout), 32'd0);

    load(48'h000000000000);
    run_word("k0_w1", 32'hABCD1234, 32'h2443c620, 0);
    run_word("k0_w2", 32'hABCD1234, 32'ha32901a6, 0);

    load(48'h12345678ABCD);
    run_word("k1_w1", 32'hABCD1234, 32'h29bd350e, 0);
    run_word("k1_w2", 32'hABCD1234, 32'hbc9cf7f9, 0);

    load(48'h12345678ABCD);
    run_word("k1_gap", 32'hABCD1234, 32'h29bd350e, 20);

    // Reset part way through a word, then reload and rerun.
    load(48'h000000000000);
    w0 = 32'hABCD1234;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] e;
      e = 32'h2443c620;
      step_bit("partial", w0[i], e[i], b);
    end
    start = 1'b1;
    do_reset();
    start = 1'b0;
    check("midreset_ks", 32'(trx_ks), 32'd0);
    check("midreset_fout", 32'(trx_fout), 32'd0);
    load(48'h000000000000);
    run_word("k0_rerun", 32'hABCD1234, 32'h2443c620, 0);

    // load_key with start on the same edge: load only, ks unchanged.
    w0       = 32'h2443c620;
    key      = 48'h000000000000;
    ser_in   = 1'b1;
    load_key = 1'b1;
    start    = 1'b1;
    tick();
    load_key = 1'b0;
    start    = 1'b0;
    check("ldstart_ks", 32'(trx_ks), 32'(w0[31]));
    check("ldstart_fout", 32'(trx_fout), 32'd0);
    run_word("ldstart_w", 32'hABCD1234, 32'h2443c620, 0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1);
  end

endmodule
